counter_universal_mod: RTL and testbench

Parametrised synchronous counter for the counters library. It generalises the fixed-width up, down and modulus counters into one block with N-bit width, MOD-n range, runtime up/down direction, and three runtime overflow modes: wrap, saturate and one-shot. It also provides terminal-count, wrap-pulse and done flags. Timers, dividers and sequencers instantiate it directly.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_next_val.sv | 47 ++++
 rtl/counter_universal_mod.sv | 80 ++++++++
 tb/tb_counter_universal_mod.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the counters library: overflow modes, FSM states and
// direction constants.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_next_val.sv
// Next-count datapath: one step of the counter for a given direction and
// overflow mode, plus terminal/wrap/one-shot event flags.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int unsigned      N   = 8,
  parameter longint unsigned  MOD = 256
) (
  input  logic [N-1:0] count,
  input  logic         dir,
  input  mode_e        mode,
  output logic [N-1:0] next_count_c,
  output logic         at_term_c,
  output logic         wrap_c,
  output logic         enter_done_c
);

  // Highest count value; MOD=2^N truncates cleanly to all ones.
  localparam logic [N-1:0] MAX_N = N'(MOD - 64'd1);

  logic [N:0] count_w;
  assign count_w = {1'b0, count};

  always_comb begin
    next_count_c = count;
    wrap_c       = 1'b0;
    enter_done_c = 1'b0;
    at_term_c    = (dir == DIR_UP) ? (count == MAX_N) : (count == '0);

    if (mode != MODE_HOLD) begin
      if (!at_term_c) begin
        next_count_c = (dir == DIR_UP) ? N'(count_w + (N+1)'(1))
                                       : N'(count_w - (N+1)'(1));
      end else begin
        case (mode)
          MODE_WRAP: begin
            next_count_c = (dir == DIR_UP) ? '0 : MAX_N;
            wrap_c       = 1'b1;
          end
          MODE_ONESHOT: enter_done_c = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule : counter_next_val

// File: rtl/counter_universal_mod.sv
// Universal MOD-n up/down counter with wrap, saturate and one-shot overflow
// modes, terminal-count, wrap-pulse and done flags.
module counter_universal_mod
  import counter_pkg::*;
#(
  parameter int unsigned     N   = 8,
  parameter longint unsigned MOD = 256
) (
  input  logic         clk,
  input  logic         reset_ah_in,
  input  logic         en_in,
  input  logic         load_in,
  input  logic [N-1:0] d_in,
  input  logic         dir_in,
  input  logic [1:0]   mode_in,
  output logic [N-1:0] count_out,
  output logic         tc_out,
  output logic         wrap_out,
  output logic         done_out
);

  localparam logic [N:0]   MOD_W = (N+1)'(MOD);
  localparam logic [N-1:0] MAX_N = N'(MOD - 64'd1);

  if ((MOD < 64'd2) || (MOD > (64'd1 << N))) begin : g_mod_check
    $error("counter_universal_mod: MOD must lie in 2..2^N");
  end

  state_e       state_q, state_d;
  logic [N-1:0] count_d;
  logic         wrap_d, done_d;
  logic [N-1:0] step_count;
  logic         step_wrap, step_done;

  counter_next_val #(.N(N), .MOD(MOD)) u_next (
    .count        (count_out),
    .dir          (dir_in),
    .mode         (mode_e'(mode_in)),
    .next_count_c (step_count),
    .at_term_c    (tc_out),
    .wrap_c       (step_wrap),
    .enter_done_c (step_done)
  );

  // Load beats counting; DONE freezes the count until reset or load.
  always_comb begin
    state_d = state_q;
    count_d = count_out;
    wrap_d  = 1'b0;
    done_d  = (state_q == ST_DONE);

    if (load_in) begin
      count_d = ({1'b0, d_in} >= MOD_W) ? MAX_N : d_in;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (en_in && (state_q == ST_RUN)) begin
      count_d = step_count;
      wrap_d  = step_wrap;
      if (step_done) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state_q   <= ST_RUN;
      count_out <= '0;
      wrap_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_out <= count_d;
      wrap_out  <= wrap_d;
      done_out  <= done_d;
    end
  end

endmodule : counter_universal_mod

// File: tb/tb_counter_universal_mod.sv
// Bench for counter_universal_mod: directed scenarios plus random stimulus
// against an arithmetic reference model, on MOD=10, MOD=16 and MOD=2 instances.
module tb_counter_universal_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, load = 1'b0, dir = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] d8 = '0;
  logic [3:0] d16 = '0;
  logic       d2 = 1'b0;

  logic [7:0] cnt8;  logic tc8,  wr8,  dn8;
  logic [3:0] cnt16; logic tc16, wr16, dn16;
  logic       cnt2;  logic tc2,  wr2,  dn2;

  int n_checks = 0;
  int n_fail   = 0;

  int m8_cnt = 0,  m16_cnt = 0,  m2_cnt = 0;
  bit m8_done = 0, m16_done = 0, m2_done = 0;
  bit m8_wrap = 0, m16_wrap = 0, m2_wrap = 0;

  always #5 clk = ~clk;

  counter_universal_mod #(.N(8), .MOD(10)) dut (
    .clk(clk), .reset_ah_in(rst), .en_in(en), .load_in(load), .d_in(d8),
    .dir_in(dir), .mode_in(mode), .count_out(cnt8), .tc_out(tc8),
    .wrap_out(wr8), .done_out(dn8));

  counter_universal_mod #(.N(4), .MOD(16)) dut16 (
    .clk(clk), .reset_ah_in(rst), .en_in(en), .load_in(load), .d_in(d16),
    .dir_in(dir), .mode_in(mode), .count_out(cnt16), .tc_out(tc16),
    .wrap_out(wr16), .done_out(dn16));

  counter_universal_mod #(.N(1), .MOD(2)) dut2 (
    .clk(clk), .reset_ah_in(rst), .en_in(en), .load_in(load), .d_in(d2),
    .dir_in(dir), .mode_in(mode), .count_out(cnt2), .tc_out(tc2),
    .wrap_out(wr2), .done_out(dn2));

  // Reference behaviour of one clock edge, straight from the counting rules.
  function automatic void model_step(input int mod, input bit r, input bit ld,
                                     input bit e, input bit up, input bit [1:0] md,
                                     input int d, inout int cnt, inout bit done,
                                     output bit wrap);
    bit at_end;
    wrap = 0;
    if (r) begin
      cnt = 0; done = 0;
    end else if (ld) begin
      cnt = (d >= mod) ? mod - 1 : d; done = 0;
    end else if (e && !done && md != 2'b11) begin
      at_end = up ? (cnt == mod - 1) : (cnt == 0);
      if (!at_end)            cnt = up ? cnt + 1 : cnt - 1;
      else if (md == 2'b00) begin cnt = up ? 0 : mod - 1; wrap = 1; end
      else if (md == 2'b10)   done = 1;
    end
  endfunction

  function automatic bit model_tc(input int mod, input int cnt, input bit up);
    return up ? (cnt == mod - 1) : (cnt == 0);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(10, rst, load, en, dir, mode, int'(d8),  m8_cnt,  m8_done,  m8_wrap);
    model_step(16, rst, load, en, dir, mode, int'(d16), m16_cnt, m16_done, m16_wrap);
    model_step(2,  rst, load, en, dir, mode, int'(d2),  m2_cnt,  m2_done,  m2_wrap);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; load = 0; en = 0;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    dir = 0; mode = 2'b00;
    do_reset();
    n_checks++;
    if ({cnt8, wr8, dn8, tc8} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_dn: got cnt=%0d wrap=%b done=%b tc=%b, want 0 0 0 1", cnt8, wr8, dn8, tc8);
    end
    dir = 1; #1;
    n_checks++;
    if (tc8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc_up: got tc=%b, want 0", tc8);
    end
  endtask

  task automatic test_up_wrap();
    int exp_c [11];
    exp_c = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    dir = 1; mode = 2'b00;
    do_reset();
    en = 1;
    for (int i = 0; i < 11; i++) begin
      cycle();
      n_checks++;
      if ({cnt8, wr8, tc8} !== {8'(exp_c[i]), 1'(i == 9), 1'(exp_c[i] == 9)}) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got cnt=%0d wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                 i, cnt8, wr8, tc8, exp_c[i], i == 9, exp_c[i] == 9);
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp_c [4];
    exp_c = '{1, 0, 9, 8};
    dir = 0; mode = 2'b00; en = 1; load = 1; d8 = 8'd2;
    cycle();
    load = 0;
    n_checks++;
    if (cnt8 !== 8'd2) begin
      n_fail++; $display("FAIL down_load: got cnt=%0d, want 2", cnt8);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if ({cnt8, wr8, tc8} !== {8'(exp_c[i]), 1'(i == 2), 1'(exp_c[i] == 0)}) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: got cnt=%0d wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                 i, cnt8, wr8, tc8, exp_c[i], i == 2, exp_c[i] == 0);
      end
    end
  endtask

  task automatic test_saturate();
    int exp_c [5];
    exp_c = '{8, 9, 9, 9, 9};
    dir = 1; mode = 2'b01; en = 1; load = 1; d8 = 8'd7;
    cycle();
    load = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if ({cnt8, wr8, dn8} !== {8'(exp_c[i]), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got cnt=%0d wrap=%b done=%b, want cnt=%0d wrap=0 done=0",
                 i, cnt8, wr8, dn8, exp_c[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_c [7];
    exp_c = '{2, 1, 0, 0, 0, 0, 0};
    dir = 0; mode = 2'b10; en = 1; load = 1; d8 = 8'd3;
    cycle();
    load = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      n_checks++;
      if ({cnt8, dn8, wr8} !== {8'(exp_c[i]), 1'(i >= 3), 1'b0}) begin
        n_fail++;
        $display("FAIL oneshot[%0d]: got cnt=%0d done=%b wrap=%b, want cnt=%0d done=%b wrap=0",
                 i, cnt8, dn8, wr8, exp_c[i], i >= 3);
      end
    end
    mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({cnt8, dn8} !== {8'd0, 1'b1}) begin
        n_fail++; $display("FAIL done_frozen[%0d]: got cnt=%0d done=%b, want 0 1", i, cnt8, dn8);
      end
    end
    load = 1; d8 = 8'd5;
    cycle();
    load = 0; en = 0;
    n_checks++;
    if ({cnt8, dn8} !== {8'd5, 1'b0}) begin
      n_fail++; $display("FAIL done_reload: got cnt=%0d done=%b, want 5 0", cnt8, dn8);
    end
  endtask

  task automatic test_load_clamp();
    load = 1; d8 = 8'd15;
    cycle();
    n_checks++;
    if (cnt8 !== 8'd9) begin
      n_fail++; $display("FAIL load_clamp: got cnt=%0d, want 9", cnt8);
    end
    rst = 1; d8 = 8'd4;
    cycle();
    rst = 0; load = 0;
    n_checks++;
    if (cnt8 !== 8'd0) begin
      n_fail++; $display("FAIL load_vs_reset: got cnt=%0d, want 0", cnt8);
    end
  endtask

  task automatic test_reset_mid();
    dir = 1; mode = 2'b00;
    do_reset();
    en = 1;
    repeat (5) cycle();
    n_checks++;
    if (cnt8 !== 8'd5) begin
      n_fail++; $display("FAIL mid_pre: got cnt=%0d, want 5", cnt8);
    end
    rst = 1;
    cycle();
    rst = 0; en = 0;
    n_checks++;
    if ({cnt8, wr8, dn8} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: got cnt=%0d wrap=%b done=%b, want 0 0 0", cnt8, wr8, dn8);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({cnt8, wr8} !== {8'd0, 1'b0}) begin
        n_fail++; $display("FAIL idle_hold[%0d]: got cnt=%0d wrap=%b, want 0 0", i, cnt8, wr8);
      end
    end
  endtask

  task automatic test_mod16();
    dir = 1; mode = 2'b00;
    do_reset();
    en = 1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      n_checks++;
      if ({cnt16, wr16, tc16} !== {4'(i % 16), 1'(i == 16), 1'(i == 15)}) begin
        n_fail++;
        $display("FAIL mod16[%0d]: got cnt=%0d wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                 i, cnt16, wr16, tc16, i % 16, i == 16, i == 15);
      end
    end
  endtask

  task automatic test_back_to_back();
    dir = 1; mode = 2'b00;
    do_reset();
    en = 1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      n_checks++;
      if ({cnt2, wr2} !== {1'(i % 2), 1'(i % 2 == 0)}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got cnt=%0d wrap=%b, want cnt=%0d wrap=%b",
                 i, cnt2, wr2, i % 2, i % 2 == 0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom % 40) == 0;
      load = ($urandom % 10) == 0;
      en   = ($urandom % 4) != 0;
      dir  = 1'($urandom);
      mode = 2'($urandom);
      d8   = 8'($urandom % 20);
      d16  = 4'($urandom);
      d2   = 1'($urandom);
      cycle();
      n_checks++;
      if ({cnt8, wr8, dn8, tc8} !== {8'(m8_cnt), m8_wrap, m8_done, model_tc(10, m8_cnt, dir)}) begin
        n_fail++;
        $display("FAIL rand_mod10[%0d]: got cnt=%0d wrap=%b done=%b tc=%b, want cnt=%0d wrap=%b done=%b tc=%b",
                 i, cnt8, wr8, dn8, tc8, m8_cnt, m8_wrap, m8_done, model_tc(10, m8_cnt, dir));
      end
      n_checks++;
      if ({cnt16, wr16, dn16, tc16} !== {4'(m16_cnt), m16_wrap, m16_done, model_tc(16, m16_cnt, dir)}) begin
        n_fail++;
        $display("FAIL rand_mod16[%0d]: got cnt=%0d wrap=%b done=%b tc=%b, want cnt=%0d wrap=%b done=%b tc=%b",
                 i, cnt16, wr16, dn16, tc16, m16_cnt, m16_wrap, m16_done, model_tc(16, m16_cnt, dir));
      end
      n_checks++;
      if ({cnt2, wr2, dn2, tc2} !== {1'(m2_cnt), m2_wrap, m2_done, model_tc(2, m2_cnt, dir)}) begin
        n_fail++;
        $display("FAIL rand_mod2[%0d]: got cnt=%0d wrap=%b done=%b tc=%b, want cnt=%0d wrap=%b done=%b tc=%b",
                 i, cnt2, wr2, dn2, tc2, m2_cnt, m2_wrap, m2_done, model_tc(2, m2_cnt, dir));
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_oneshot();
    test_load_clamp();
    test_reset_mid();
    test_mod16();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_counter_universal_mod
